comp_operand_loader: RTL and testbench
======================================

// Module: comp_operand_loader
// PURPOSE
//  Upstream operand-assembly stage for the 8-bit magnitude comparator.
//  Receives operands A and B as two parallel serial bit streams.
//  Deserialises them with a start/valid/ack handshake.
//  Presents stable parallel words on a_out/b_out. These wire straight to the
//  comparator's A/B inputs and never change while a result is being consumed.
// PARAMETERS
//  WIDTH      8   operand width in bits (legal range 2..32)
//  MSB_FIRST  1   1: first serial bit is bit WIDTH-1; 0: first bit is bit 0
// PORTS
//  clk     in   1      system clock, all state updates on rising edge
//  rst     in   1      asynchronous, active-high reset
//  start   in   1      request a new load; sampled only in IDLE (and HOLD with ack)
//  ser_a   in   1      serial data bit for operand A
//  ser_b   in   1      serial data bit for operand B
//  ack     in   1      consumer has taken the current operand pair
//  a_out   out  WIDTH  assembled operand A (registered)
//  b_out   out  WIDTH  assembled operand B (registered)
//  busy    out  1      1 while in SHIFT
//  valid   out  1      1 while in HOLD: a_out/b_out hold a fresh pair
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, a_out=b_out=0, shift regs=0,
//   bit counter=0, busy=0, valid=0. Reset mid-SHIFT aborts the load.
//  FSM states: IDLE, SHIFT, HOLD. Outputs busy/valid decode from the state.
//  IDLE: start=1 at edge t0 -> SHIFT. Counter cleared. No bit is sampled at t0.
//  SHIFT: ser_a/ser_b sampled into internal shift regs on edges t1..tWIDTH.
//   - Counter counts sampled bits, width $clog2(WIDTH+1).
//   - start is ignored. a_out/b_out keep their previous values.
//   - MSB_FIRST=1: shift left, new bit enters at LSB.
//   - MSB_FIRST=0: shift right, new bit enters at MSB.
//  Completion edge tWIDTH: shift regs (incl. that edge's bit) copied to
//   a_out/b_out. State -> HOLD.
//  Latency: valid=1 in the cycle after edge tWIDTH.
//   Total WIDTH+1 edges from start accepted to valid.
//  HOLD: valid=1, outputs frozen.
//   - ack=1 & start=0 -> IDLE.
//   - ack=1 & start=1 -> SHIFT directly (back-to-back load, counter cleared).
//   - start without ack is ignored.
//   - a_out/b_out stay unchanged until the next completion edge, so the
//     comparator inputs are stable through the entire next load.
//  ack outside HOLD is ignored. Serial inputs outside SHIFT are ignored.
//  No wrap-around: counter saturates at WIDTH only by leaving SHIFT.
// TESTING
//  1 Reset: assert rst mid-cycle -> a_out=b_out=0, busy=0, valid=0 immediately
//    (without a clock edge).
//  2 MSB_FIRST=1: start, then A=8'b0001_0000, B=8'b0000_1000 serially
//    -> after 9 edges valid=1, a_out=8'h10, b_out=8'h08; comparator larger=1.
//  3 Hold/ack: keep ack=0 for 5 cycles with start pulsing -> valid stays 1,
//    outputs unchanged. ack=1 -> IDLE next edge, valid=0.
//  4 Back-to-back: ack=1 & start=1 in HOLD, load A=B=8'h10
//    -> busy next cycle; old 8'h10/8'h08 held until completion;
//    then a_out=b_out=8'h10.
//  5 Reset mid-SHIFT after 4 bits -> IDLE, outputs 0.
//    A fresh load A=8'h10, B=8'h20 -> a_out=8'h10, b_out=8'h20.
//  6 MSB_FIRST=0: serial bits 1,0,0,0,0,0,0,0 on ser_a -> a_out=8'h01.

Source files
------------

// File: rtl/comp_operand_loader.sv
// Serial-to-parallel operand loader feeding the magnitude comparator.
// Two serial streams are deserialised together; the finished pair is held stable until acknowledged.
module comp_operand_loader #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ser_a,
  input  logic             ser_b,
  input  logic             ack,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             busy,
  output logic             valid
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] sha_r;
  logic [WIDTH-1:0] shb_r;
  logic [WIDTH-1:0] sha_s;
  logic [WIDTH-1:0] shb_s;
  logic             load_s;
  logic             done_s;

  // sha_s/shb_s include the bit sampled on the current edge, so completion can copy them directly
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sha_s = {sha_r[WIDTH-2:0], ser_a};
      assign shb_s = {shb_r[WIDTH-2:0], ser_b};
    end else begin : g_lsb_first
      assign sha_s = {ser_a, sha_r[WIDTH-1:1]};
      assign shb_s = {ser_b, shb_r[WIDTH-1:1]};
    end
  endgenerate

  // Next-state decode; load_s marks an accepted start, done_s the completion edge
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SHIFT;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == LAST) begin
          state_s = HOLD;
          done_s  = 1'b1;
        end else begin
          state_s = SHIFT;
        end
      end
      HOLD: begin
        if (ack) begin
          load_s  = start;
          state_s = start ? SHIFT : IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register with busy/valid registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s == SHIFT);
      valid   <= (state_s == HOLD);
    end
  end

  // Bit counter, shift registers and the held output pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
      sha_r <= {WIDTH{1'b0}};
      shb_r <= {WIDTH{1'b0}};
      a_out <= {WIDTH{1'b0}};
      b_out <= {WIDTH{1'b0}};
    end else begin
      if (load_s) begin
        cnt_r <= {CW{1'b0}};
      end else if (state_r == SHIFT) begin
        cnt_r <= cnt_r + CW'(1);
        sha_r <= sha_s;
        shb_r <= shb_s;
      end else begin
        cnt_r <= cnt_r;
      end
      // Outputs only move on completion, keeping comparator inputs stable through a reload
      if (done_s) begin
        a_out <= sha_s;
        b_out <= shb_s;
      end else begin
        a_out <= a_out;
        b_out <= b_out;
      end
    end
  end

endmodule

// File: tb/tb_comp_operand_loader.sv
// Scoreboard bench for comp_operand_loader: one MSB-first and one LSB-first instance.
module tb_comp_operand_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, ser_a, ser_b, ack;
  logic [7:0] a_out, b_out;
  logic       busy, valid;
  logic       start1, ser_a1, ser_b1, ack1;
  logic [7:0] a_out1, b_out1;
  logic       busy1, valid1;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb0[$];
  logic [15:0] sb1[$];
  logic [7:0]  cur_a = 8'h00;
  logic [7:0]  cur_b = 8'h00;
  logic        valid_q  = 1'b0;
  logic        valid1_q = 1'b0;

  comp_operand_loader #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .start(start), .ser_a(ser_a), .ser_b(ser_b), .ack(ack),
    .a_out(a_out), .b_out(b_out), .busy(busy), .valid(valid)
  );

  comp_operand_loader #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .start(start1), .ser_a(ser_a1), .ser_b(ser_b1), .ack(ack1),
    .a_out(a_out1), .b_out(b_out1), .busy(busy1), .valid(valid1)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor for the MSB-first instance: every fresh valid pops one expected pair
  always @(negedge clk) begin
    if (valid && !valid_q) begin
      if (sb0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb0_unexpected actual=%0h_%0h required=none", a_out, b_out);
      end else begin
        logic [15:0] e;
        e = sb0.pop_front();
        check("sb0_a", int'(a_out), int'(e[15:8]));
        check("sb0_b", int'(b_out), int'(e[7:0]));
      end
    end
    valid_q <= valid;
  end

  // Monitor for the LSB-first instance
  always @(negedge clk) begin
    if (valid1 && !valid1_q) begin
      if (sb1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb1_unexpected actual=%0h_%0h required=none", a_out1, b_out1);
      end else begin
        logic [15:0] e;
        e = sb1.pop_front();
        check("sb1_a", int'(a_out1), int'(e[15:8]));
        check("sb1_b", int'(b_out1), int'(e[7:0]));
      end
    end
    valid1_q <= valid1;
  end

  task automatic load(input logic [7:0] a, input logic [7:0] b, input logic b2b);
    @(negedge clk);
    if (b2b) check("b2b_in_hold", int'(valid), 1);
    start = 1'b1;
    ack   = b2b;
    sb0.push_back({a, b});
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'b0;
      ack   = 1'b0;
      check("shift_busy", int'(busy), 1);
      check("shift_valid", int'(valid), 0);
      check("shift_hold_a", int'(a_out), int'(cur_a));
      check("shift_hold_b", int'(b_out), int'(cur_b));
      ser_a = a[7-i];
      ser_b = b[7-i];
    end
    @(negedge clk);
    ser_a = 1'b0;
    ser_b = 1'b0;
    check("done_valid", int'(valid), 1);
    check("done_busy", int'(busy), 0);
    cur_a = a;
    cur_b = b;
  endtask

  task automatic load1(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start1 = 1'b1;
    sb1.push_back({a, b});
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start1 = 1'b0;
      check("lsb_busy", int'(busy1), 1);
      ser_a1 = a[i];
      ser_b1 = b[i];
    end
    @(negedge clk);
    check("lsb_valid", int'(valid1), 1);
    @(negedge clk);
    ack1 = 1'b1;
    @(negedge clk);
    ack1 = 1'b0;
    check("lsb_ack_idle", int'(valid1), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ser_a = 1'b0; ser_b = 1'b0; ack = 1'b0;
    start1 = 1'b0; ser_a1 = 1'b0; ser_b1 = 1'b0; ack1 = 1'b0;
    #1;
    check("rst_a", int'(a_out), 0);
    check("rst_b", int'(b_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(valid), 0);
    @(negedge clk);
    rst = 1'b0;

    // MSB-first load; A > B for the comparator
    load(8'h10, 8'h08, 1'b0);
    check("larger", int'(a_out > b_out), 1);

    // HOLD with start pulses and no ack
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", int'(valid), 1);
      check("hold_a", int'(a_out), 32'h10);
      check("hold_b", int'(b_out), 32'h08);
      start = (i % 2 == 0);
    end
    start = 1'b0;

    // Back-to-back reload straight from HOLD
    load(8'h10, 8'h10, 1'b1);
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("ack_valid", int'(valid), 0);
    check("ack_busy", int'(busy), 0);

    // Asynchronous reset after four sampled bits
    @(negedge clk);
    start = 1'b1;
    ser_a = 1'b1;
    ser_b = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_a", int'(a_out), 0);
    check("arst_b", int'(b_out), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_valid", int'(valid), 0);
    @(negedge clk);
    rst = 1'b0;
    ser_a = 1'b0;
    ser_b = 1'b0;
    cur_a = 8'h00;
    cur_b = 8'h00;
    load(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("ack2_valid", int'(valid), 0);

    // LSB-first instance
    load1(8'h01, 8'hC4);
    load1(8'hA5, 8'h3C);

    repeat (2) @(negedge clk);
    check("sb0_empty", sb0.size(), 0);
    check("sb1_empty", sb1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
